// File: rtl/rcu_rst_seq.sv
// Reset-release sequencer: holds all domains in reset, waits for PLL lock (or bypass), then
// releases CH_NUM resets in order with a programmable gap. Lock timeout: RCU_SEQ_TIMEOUT_EN.
module rcu_rst_seq #(
    parameter int unsigned CH_NUM    = 6,
    parameter int unsigned DLY_WIDTH = 8,
    parameter int unsigned TMO_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 pll_lock_i,
    input  logic                 pll_byp_i,
    input  logic                 wdt_rst_req_i,
    input  logic [CH_NUM-1:0]    sw_rst_req_i,
    input  logic [DLY_WIDTH-1:0] cfg_dly_i,
    input  logic                 clr_i,
    output logic [CH_NUM-1:0]    rst_n_o,
    output logic                 pll_sel_o,
    output logic                 done_o,
    output logic                 tmo_o,
    output logic                 lock_lost_o
);

    localparam int unsigned IDX_W      = $clog2(CH_NUM);
    localparam int unsigned ACNT_W     = 2;
    localparam int unsigned ASSERT_CYC = 4;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                r_state;
    logic [ACNT_W-1:0]     r_acnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DLY_WIDTH-1:0]  r_dly;
    logic [DLY_WIDTH-1:0]  r_cnt;
    logic [DLY_WIDTH-1:0]  r_sw_cnt [CH_NUM];
    logic [CH_NUM-1:0]     r_rst_n;
    logic                  r_pll_sel;
    logic                  r_done;
    logic                  r_lock_lost;
    logic                  w_tmo_hit;
    logic                  w_lost_set;

`ifdef RCU_SEQ_TIMEOUT_EN
    logic [TMO_WIDTH-1:0]  r_tcnt;
    logic                  r_tmo;
    logic                  w_wait_stay;

    assign w_wait_stay = (r_state == ST_WAIT_LOCK) && !wdt_rst_req_i && !pll_byp_i && !pll_lock_i;
    assign w_tmo_hit   = w_wait_stay && (r_tcnt == {TMO_WIDTH{1'b1}});

    // Lock-wait timer; zero whenever the sequencer is not waiting for lock
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tcnt <= '0;
        end else if (w_wait_stay && !w_tmo_hit) begin
            r_tcnt <= r_tcnt + TMO_WIDTH'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tmo <= 1'b1;
        end else if (clr_i) begin
            r_tmo <= 1'b0;
        end
    end

    assign tmo_o = r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign tmo_o     = 1'b0;
`endif

    assign w_lost_set = r_pll_sel && !pll_lock_i;

    // Sticky lock-loss flag; a new event outranks a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_lost <= 1'b0;
        end else if (w_lost_set) begin
            r_lock_lost <= 1'b1;
        end else if (clr_i) begin
            r_lock_lost <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_ASSERT;
            r_acnt    <= '0;
            r_idx     <= '0;
            r_dly     <= '0;
            r_cnt     <= '0;
            r_rst_n   <= '0;
            r_pll_sel <= 1'b0;
            r_done    <= 1'b0;
            for (int k = 0; k < int'(CH_NUM); k++) begin
                r_sw_cnt[k] <= '0;
            end
        end else if (wdt_rst_req_i) begin
            r_state   <= ST_ASSERT;
            r_acnt    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rst_n   <= '0;
            r_pll_sel <= 1'b0;
            r_done    <= 1'b0;
            for (int k = 0; k < int'(CH_NUM); k++) begin
                r_sw_cnt[k] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_ASSERT: begin
                    r_rst_n   <= '0;
                    r_pll_sel <= 1'b0;
                    if (r_acnt == ACNT_W'(ASSERT_CYC - 1)) begin
                        r_acnt  <= '0;
                        r_state <= ST_WAIT_LOCK;
                    end else begin
                        r_acnt <= r_acnt + ACNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (pll_byp_i || pll_lock_i || w_tmo_hit) begin
                        r_state   <= ST_RELEASE;
                        r_pll_sel <= !pll_byp_i && pll_lock_i;
                        r_dly     <= cfg_dly_i;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == r_dly) begin
                        for (int k = 0; k < int'(CH_NUM); k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_rst_n[k] <= 1'b1;
                            end
                        end
                        r_cnt <= '0;
                        if (r_idx == IDX_W'(CH_NUM - 1)) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + DLY_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    // Per-channel soft reset: hold while requested, then count down the gap
                    for (int k = 0; k < int'(CH_NUM); k++) begin
                        if (sw_rst_req_i[k]) begin
                            r_rst_n[k]  <= 1'b0;
                            r_sw_cnt[k] <= r_dly;
                        end else if (!r_rst_n[k]) begin
                            if (r_sw_cnt[k] == '0) begin
                                r_rst_n[k] <= 1'b1;
                            end else begin
                                r_sw_cnt[k] <= r_sw_cnt[k] - DLY_WIDTH'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_ASSERT;
            endcase
        end
    end

    assign rst_n_o     = r_rst_n;
    assign pll_sel_o   = r_pll_sel;
    assign done_o      = r_done;
    assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_rcu_rst_seq.sv
// Scoreboard bench for rcu_rst_seq: stimulus queues each expected output change with its cycle,
// a negedge monitor pops and compares whenever the output vector changes.
module tb_rcu_rst_seq;

    localparam int unsigned CH_NUM    = 6;
    localparam int unsigned DLY_WIDTH = 8;
    localparam int unsigned TMO_WIDTH = 4;

    logic                 clk;
    logic                 rst_n_i;
    logic                 pll_lock_i;
    logic                 pll_byp_i;
    logic                 wdt_rst_req_i;
    logic [CH_NUM-1:0]    sw_rst_req_i;
    logic [DLY_WIDTH-1:0] cfg_dly_i;
    logic                 clr_i;
    logic [CH_NUM-1:0]    rst_n_o;
    logic                 pll_sel_o;
    logic                 done_o;
    logic                 tmo_o;
    logic                 lock_lost_o;

    rcu_rst_seq #(
        .CH_NUM    (CH_NUM),
        .DLY_WIDTH (DLY_WIDTH),
        .TMO_WIDTH (TMO_WIDTH)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .pll_lock_i    (pll_lock_i),
        .pll_byp_i     (pll_byp_i),
        .wdt_rst_req_i (wdt_rst_req_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .cfg_dly_i     (cfg_dly_i),
        .clr_i         (clr_i),
        .rst_n_o       (rst_n_o),
        .pll_sel_o     (pll_sel_o),
        .done_o        (done_o),
        .tmo_o         (tmo_o),
        .lock_lost_o   (lock_lost_o)
    );

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } exp_t;

    exp_t        q[$];
    string       q_nm[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          cyc    = 0;
    logic [5:0]  e_rst;
    logic        e_sel, e_done, e_tmo, e_lost;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge count since the last reset release; edge n after release reads as cyc==n
    always @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic push(input int c, input string nm);
        exp_t e;
        e.cyc = c;
        e.val = {e_rst, e_sel, e_done, e_tmo, e_lost};
        q.push_back(e);
        q_nm.push_back(nm);
    endtask

    task automatic release_chans(input int entry, input int gap, input string nm);
        for (int k = 0; k < 6; k++) begin
            e_rst[k] = 1'b1;
            if (k == 5) e_done = 1'b1;
            push(entry + gap * (k + 1), $sformatf("%s_ch%0d", nm, k));
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output vector must match the next queued expectation
    logic [9:0] prev;
    logic       first = 1'b1;
    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t       ex;
        string      nm;
        cur = {rst_n_o, pll_sel_o, done_o, tmo_o, lock_lost_o};
        if (first || cur != prev) begin
            n_chk = n_chk + 1;
            if (q.size() == 0) begin
                $display("FAIL unexpected_change: got cyc=%0d out=%b, expected no change", cyc, cur);
            end else begin
                ex = q.pop_front();
                nm = q_nm.pop_front();
                if (ex.cyc != cyc || ex.val != cur)
                    $display("FAIL %s: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                             nm, cyc, cur, ex.cyc, ex.val);
                else
                    n_pass = n_pass + 1;
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cyc=%0d, expected end of stimulus", cyc);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int tend;
        rst_n_i       = 1'b1;
        pll_byp_i     = 1'b1;
        pll_lock_i    = 1'b0;
        wdt_rst_req_i = 1'b0;
        sw_rst_req_i  = '0;
        cfg_dly_i     = 8'd2;
        clr_i         = 1'b0;
        e_rst = '0; e_sel = 1'b0; e_done = 1'b0; e_tmo = 1'b0; e_lost = 1'b0;
        push(0, "reset");
        #1 rst_n_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;

        // Bypass sequence, gap 3; dly change mid-RELEASE must not take effect
        release_chans(5, 3, "byp");
        wait_until(9);  cfg_dly_i = 8'd3;
        wait_until(25);

        // Watchdog from RUN, then lock path with lock after 10 WAIT_LOCK cycles
        e_rst = '0; e_sel = 1'b0; e_done = 1'b0;
        push(26, "wdt_run");
        e_sel = 1'b1;
        push(41, "lock_sel");
        release_chans(41, 4, "lock");
        pll_byp_i = 1'b0; wdt_rst_req_i = 1'b1;
        wait_until(26); wdt_rst_req_i = 1'b0;
        wait_until(40); pll_lock_i = 1'b1;

        // Software reset on channel 2 for 5 cycles, gap 4
        e_rst = 6'b111011; push(71, "sw_low");
        e_rst = 6'b111111; push(79, "sw_high");
        wait_until(70); sw_rst_req_i = 6'b000100;
        wait_until(75); sw_rst_req_i = '0;

        // Lock loss, clear, and set-wins-over-clear
        e_lost = 1'b1; push(86, "lost_set");
        e_lost = 1'b0; push(91, "lost_clr");
        e_lost = 1'b1; push(96, "lost_set_wins");
        wait_until(85); pll_lock_i = 1'b0;
        wait_until(86); pll_lock_i = 1'b1;
        wait_until(90); clr_i = 1'b1;
        wait_until(91); clr_i = 1'b0;
        wait_until(95); clr_i = 1'b1; pll_lock_i = 1'b0;
        wait_until(96); clr_i = 1'b0; pll_lock_i = 1'b1;

        // Held watchdog, bypass restart gap 2, sw request ignored in RELEASE, watchdog mid-RELEASE
        e_rst = '0; e_sel = 1'b0; e_done = 1'b0;
        push(101, "wdt_hold");
        e_rst = 6'b000001; push(110, "rel_ch0");
        e_rst = 6'b000011; push(112, "rel_ch1");
        e_rst = '0;        push(114, "wdt_release");
        release_chans(119, 2, "restart");
        wait_until(100); wdt_rst_req_i = 1'b1; pll_byp_i = 1'b1; cfg_dly_i = 8'd1;
        wait_until(103); wdt_rst_req_i = 1'b0;
        wait_until(110); sw_rst_req_i = 6'b000001;
        wait_until(113); sw_rst_req_i = '0; wdt_rst_req_i = 1'b1;
        wait_until(114); wdt_rst_req_i = 1'b0;

        // Lock never arrives
        e_rst = '0; e_done = 1'b0;
        push(136, "wdt_tmo");
`ifdef RCU_SEQ_TIMEOUT_EN
        e_tmo = 1'b1;
        push(156, "tmo_set");
        release_chans(156, 2, "tmo");
        tend = 175;
`else
        tend = 1140;
`endif
        wait_until(135); wdt_rst_req_i = 1'b1; pll_byp_i = 1'b0; pll_lock_i = 1'b0;
        wait_until(136); wdt_rst_req_i = 1'b0;
        wait_until(tend);

        // Short async reset pulse between clock edges
        e_rst = '0; e_sel = 1'b0; e_done = 1'b0; e_tmo = 1'b0; e_lost = 1'b0;
        push(0, "async_rst");
        #2 rst_n_i = 1'b0;
        #1 rst_n_i = 1'b1;
        wait_until(4);

        n_chk = n_chk + 1;
        if (q.size() != 0)
            $display("FAIL pending_changes: got %0d unseen, first %s at cyc=%0d, expected 0",
                     q.size(), q_nm[0], q[0].cyc);
        else
            n_pass = n_pass + 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rcu_rst_seq.md
# rcu_rst_seq

Parametrised reset-release sequencer for the RCU, the successor to the fixed six-domain `rst_sync` fan-out. After a system or watchdog reset it holds every domain in reset and waits for PLL lock, with an optional bypass and timeout fallback. It then releases `CH_NUM` domain resets one at a time with a programmable inter-channel gap. It also supports per-channel software reset and sticky lock-loss/timeout flags. It sits in the RCU between the register file (config/status) and the per-domain `rst_sync` stages.

## Interface
- `CH_NUM`, 6: number of reset channels (2..16)
- `DLY_WIDTH`, 8: width of inter-channel delay
- `TMO_WIDTH`, 16: width of PLL-lock timeout counter
- `clk_i` in 1: sequencer clock (APB/ref clock)
- `rst_n_i` in 1: asynchronous active-low reset
- `pll_lock_i` in 1: PLL lock indication, already synchronous to `clk_i`
- `pll_byp_i` in 1: 1 = skip lock wait, run from bypass clock
- `wdt_rst_req_i` in 1: watchdog/system reset request, level
- `sw_rst_req_i` in `CH_NUM`: per-channel software reset request, level
- `cfg_dly_i` in `DLY_WIDTH`: inter-channel gap; the gap is `cfg_dly_i`+1 cycles
- `clr_i` in 1: clears the sticky flags, single-cycle pulse
- `rst_n_o` out `CH_NUM`: per-channel reset, active-low, registered
- `pll_sel_o` out 1: 1 = core clock from PLL, 0 = bypass
- `done_o` out 1: sequence complete (state RUN)
- `tmo_o` out 1: sticky, lock timeout occurred
- `lock_lost_o` out 1: sticky, lock dropped while `pll_sel_o`=1

## Operation
- FSM states: ASSERT, WAIT_LOCK, RELEASE, RUN.
- Reset values: state ASSERT, `rst_n_o`=0, `pll_sel_o`=0, `done_o`=0, `tmo_o`=0, `lock_lost_o`=0, all counters 0.
- ASSERT
  - All `rst_n_o`=0, `pll_sel_o`=0.
  - Stays exactly 4 cycles, then moves to WAIT_LOCK.
- WAIT_LOCK
  - If `pll_byp_i`=1: go to RELEASE with `pll_sel_o`=0.
  - Else if `pll_lock_i`=1: go to RELEASE with `pll_sel_o`=1.
  - Otherwise the timeout counter increments (timeout behaviour under Configuration).
- RELEASE
  - On entry, `cfg_dly_i` is latched and idx=0, cnt=0. Later changes to `cfg_dly_i` have no effect until the next RELEASE.
  - cnt increments each cycle. When cnt==latched dly: `rst_n_o[idx]` is set to 1, idx++, cnt=0.
  - Release order is always bit 0 first, bit `CH_NUM`-1 last.
  - The edge that releases channel `CH_NUM`-1 also enters RUN.
- RUN
  - `done_o`=1.
  - `pll_lock_i`=0 while `pll_sel_o`=1 sets `lock_lost_o`. The sequencer stays in RUN; no automatic reset.
- Software reset: `sw_rst_req_i[k]`=1 in RUN forces `rst_n_o[k]`=0 next cycle.
  - A per-channel counter loads the latched dly and counts down after the request drops.
  - `rst_n_o[k]` returns to 1 `dly`+1 cycles after the request's falling edge.
  - Each channel has its own counter. Requests outside RUN are ignored.
- Watchdog: `wdt_rst_req_i`=1 in any state moves to ASSERT on the next edge, clearing `done_o`, `pll_sel_o`, idx, cnt and all software-reset counters.
  - The sticky flags are kept.
  - While held, it restarts ASSERT's 4-cycle count every cycle.
- Priority: `wdt_rst_req_i` > `sw_rst_req_i` > sequencing.
- Flag clearing: `clr_i` clears `tmo_o` and `lock_lost_o`. If a set event and `clr_i` occur in the same cycle, set wins.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Channel k rises (`cfg_dly_i`+1)*(k+1) cycles after the RELEASE-entry edge.
- `done_o` rises in the same cycle as `rst_n_o[CH_NUM-1]`.
- Bypass example (`pll_byp_i`=1, dly=0, `CH_NUM`=6), counting edges after `rst_n_i` deasserts:
  - Edges 1-4: ASSERT.
  - Edge 5: enters RELEASE.
  - Edges 6..11: `rst_n_o[0]`..`rst_n_o[5]` rise.
  - `done_o` rises at edge 11.
- Mid-sequence `rst_n_i` assertion: all outputs return to reset values immediately (asynchronous).

## Configuration
- `RCU_SEQ_TIMEOUT_EN` defined:
  - The `TMO_WIDTH` counter runs in WAIT_LOCK.
  - After 2^`TMO_WIDTH` cycles without lock: set `tmo_o`, go to RELEASE with `pll_sel_o`=0 (bypass fallback).
  - The counter clears on leaving WAIT_LOCK.
- Not defined:
  - No timeout counter; WAIT_LOCK waits indefinitely.
  - `tmo_o` is tied to 0.

## Test plan
- Bypass sequence, `CH_NUM`=6, dly=2: channel k rises 3*(k+1) cycles after RELEASE entry; `done_o` rises with `rst_n_o[5]` 18 cycles after entry; `pll_sel_o`=0.
- Lock path, `pll_byp_i`=0, `pll_lock_i` rises 10 cycles into WAIT_LOCK: next edge enters RELEASE; `pll_sel_o`=1.
- Timeout: with `RCU_SEQ_TIMEOUT_EN`, `TMO_WIDTH`=4, lock never rises: after 16 WAIT_LOCK cycles `tmo_o`=1 and RELEASE starts with `pll_sel_o`=0.
  - Without the macro: sequencer remains in WAIT_LOCK for 1000 cycles with `tmo_o`=0.
- Software reset: in RUN with dly=3, pulse `sw_rst_req_i[2]` for 5 cycles:
  - `rst_n_o[2]` is low from the next edge, high 4 cycles after the request falls.
  - All other channels stay 1.
- Watchdog during RELEASE (after channel 1 released): next edge all `rst_n_o`=0 and `done_o`=0; full sequence restarts; `tmo_o`/`lock_lost_o` retained.
- Lock loss in RUN with `pll_sel_o`=1: drop `pll_lock_i` 1 cycle → `lock_lost_o`=1 and stays set.
  - `clr_i` then clears it.
  - `clr_i` in the same cycle as a new drop leaves it at 1.
